// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID register, one-entry skid buffer and HALT detection.
//
// Ports:
//   CLK            in   1   clock, all state updates on rising edge
//   nRST           in   1   synchronous active-low reset
//   pcaddr         in  32   current PC
//   next_pc        in  32   pcaddr+4
//   ihit           in   1   icache hit, iload valid this cycle
//   iload          in  32   instruction word from icache
//   id_stall       in   1   decode cannot accept a new instruction
//   flush          in   1   redirect from downstream, discard fetched work
//   iREN           out  1   instruction read request
//   iaddr          out 32   instruction read address
//   pcen           out  1   PC advance enable
//   id_valid       out  1   IF/ID holds a live instruction
//   id_instruction out 32   IF/ID instruction, zero when invalid
//   id_npc         out 32   next_pc captured alongside the instruction
//   halted         out  1   HALT has entered IF/ID, fetch stopped
module fetch_unit (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pcaddr,
    input  logic [31:0] next_pc,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        id_stall,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic        pcen,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_npc,
    output logic        halted
);
    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] WAIT_ID = 2'd1;
    localparam logic [1:0] HALT    = 2'd2;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [1:0]  r_state;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_npc;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_npc;
    logic        w_fetch;
    logic        w_to_skid;

    assign w_fetch   = r_state == FETCH;
    // IF/ID is occupied and decode is stalled: the hit must park in the skid
    assign w_to_skid = r_valid && id_stall;

    assign iREN           = nRST && w_fetch;
    assign iaddr          = pcaddr;
    // every hit in FETCH is accepted (IF/ID or skid), so the PC always advances on it
    assign pcen           = nRST && (flush || (w_fetch && ihit));
    assign id_valid       = r_valid;
    assign id_instruction = r_valid ? r_instr : 32'h0;
    assign id_npc         = r_npc;
    assign halted         = r_state == HALT;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state      <= FETCH;
            r_valid      <= 1'b0;
            r_instr      <= 32'h0;
            r_npc        <= 32'h0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= 32'h0;
            r_skid_npc   <= 32'h0;
        end else if (flush) begin
            r_state      <= FETCH;
            r_valid      <= 1'b0;
            r_instr      <= 32'h0;
            r_skid_valid <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (ihit && w_to_skid) begin
                        r_skid_valid <= 1'b1;
                        r_skid_instr <= iload;
                        r_skid_npc   <= next_pc;
                        r_state      <= WAIT_ID;
                    end else if (ihit) begin
                        r_valid <= 1'b1;
                        r_instr <= iload;
                        r_npc   <= next_pc;
                        r_state <= iload[31:26] == OP_HALT ? HALT : FETCH;
                    end else if (!id_stall) begin
                        r_valid <= 1'b0;
                        r_instr <= 32'h0;
                    end
                end
                WAIT_ID: begin
                    if (!id_stall) begin
                        r_valid      <= r_skid_valid;
                        r_instr      <= r_skid_instr;
                        r_npc        <= r_skid_npc;
                        r_skid_valid <= 1'b0;
                        r_state      <= r_skid_instr[31:26] == OP_HALT ? HALT : FETCH;
                    end
                end
                HALT: r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector-table and scoreboard bench for fetch_unit.
module tb_fetch_unit;
    typedef struct {
        logic        n;
        logic        f;
        logic        h;
        logic        s;
        logic [31:0] ld;
        logic [31:0] npc;
        logic        e_pcen;
        logic        e_iren;
        logic        e_v;
        logic [31:0] e_ins;
        logic [31:0] e_npc;
        logic        e_hl;
    } vec_t;

    typedef struct {
        int          idx;
        logic        v;
        logic [31:0] ins;
        logic [31:0] npc;
        logic        hl;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] pcaddr = 32'h0;
    logic [31:0] next_pc = 32'h4;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'h0;
    logic        id_stall = 1'b0;
    logic        flush = 1'b0;
    logic        iREN;
    logic [31:0] iaddr;
    logic        pcen;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_npc;
    logic        halted;

    int   n_tests = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    exp_t sb[$];

    fetch_unit dut (
        .CLK(CLK), .nRST(nRST), .pcaddr(pcaddr), .next_pc(next_pc), .ihit(ihit),
        .iload(iload), .id_stall(id_stall), .flush(flush), .iREN(iREN), .iaddr(iaddr),
        .pcen(pcen), .id_valid(id_valid), .id_instruction(id_instruction),
        .id_npc(id_npc), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic add(input logic n, input logic f, input logic h, input logic s,
                       input logic [31:0] ld, input logic [31:0] npc,
                       input logic ep, input logic ei, input logic ev,
                       input logic [31:0] eins, input logic [31:0] enpc, input logic eh);
        vec_t t;
        t.n = n; t.f = f; t.h = h; t.s = s; t.ld = ld; t.npc = npc;
        t.e_pcen = ep; t.e_iren = ei; t.e_v = ev; t.e_ins = eins; t.e_npc = enpc; t.e_hl = eh;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    // Drives one vector just after a rising edge, checks the combinational
    // outputs mid-cycle, and queues the registered results for after the edge.
    task automatic step(input int idx, input vec_t t);
        exp_t e;
        exp_t p;
        nRST = t.n; flush = t.f; ihit = t.h; id_stall = t.s; iload = t.ld;
        next_pc = t.npc; pcaddr = t.npc - 32'd4;
        #3;
        check("pcen", idx, {31'b0, pcen}, {31'b0, t.e_pcen});
        check("iREN", idx, {31'b0, iREN}, {31'b0, t.e_iren});
        check("iaddr", idx, iaddr, t.npc - 32'd4);
        e.idx = idx; e.v = t.e_v; e.ins = t.e_ins; e.npc = t.e_npc; e.hl = t.e_hl;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard vec %0d: queue empty", idx);
        end else begin
            p = sb.pop_front();
            check("id_valid", p.idx, {31'b0, id_valid}, {31'b0, p.v});
            check("id_instruction", p.idx, id_instruction, p.ins);
            check("id_npc", p.idx, id_npc, p.npc);
            check("halted", p.idx, {31'b0, halted}, {31'b0, p.hl});
        end
    endtask

    initial begin
        vec_t t;
        // reset
        add(0,0,0,0, 32'h0,        32'h4,  0,0, 0,32'h0,        32'h0,  0);
        // streaming
        add(1,0,1,0, 32'h20010001, 32'h4,  1,1, 1,32'h20010001, 32'h4,  0);
        add(1,0,1,0, 32'h20020002, 32'h8,  1,1, 1,32'h20020002, 32'h8,  0);
        add(1,0,1,0, 32'h20030003, 32'hC,  1,1, 1,32'h20030003, 32'hC,  0);
        // cache miss: bubble after first edge, npc retained
        for (int i = 0; i < 4; i++)
            add(1,0,0,0, 32'h0,    32'h10, 0,1, 0,32'h0,        32'hC,  0);
        // stalled with no hit holds IF/ID
        add(1,0,1,0, 32'h11111111, 32'h14, 1,1, 1,32'h11111111, 32'h14, 0);
        add(1,0,0,1, 32'h0,        32'h18, 0,1, 1,32'h11111111, 32'h14, 0);
        // skid capture, hold, release
        add(1,0,1,1, 32'h8C220004, 32'h18, 1,1, 1,32'h11111111, 32'h14, 0);
        add(1,0,0,1, 32'h0,        32'h1C, 0,0, 1,32'h11111111, 32'h14, 0);
        add(1,0,0,0, 32'h0,        32'h1C, 0,0, 1,32'h8C220004, 32'h18, 0);
        add(1,0,1,0, 32'h22222222, 32'h1C, 1,1, 1,32'h22222222, 32'h1C, 0);
        // flush with ihit while in WAIT_ID
        add(1,0,1,1, 32'h33333333, 32'h20, 1,1, 1,32'h22222222, 32'h1C, 0);
        add(1,1,1,1, 32'h44444444, 32'h24, 1,0, 0,32'h0,        32'h1C, 0);
        add(1,0,0,0, 32'h0,        32'h24, 0,1, 0,32'h0,        32'h1C, 0);
        // halt from FETCH, held 10 cycles (one stray ihit ignored), then flush
        add(1,0,1,0, 32'hFC000000, 32'h28, 1,1, 1,32'hFC000000, 32'h28, 1);
        for (int i = 0; i < 10; i++)
            add(1,0,i == 4,0, 32'h55555555, 32'h2C, 0,0, 1,32'hFC000000, 32'h28, 1);
        add(1,1,0,0, 32'h0,        32'h2C, 1,0, 0,32'h0,        32'h28, 0);
        add(1,0,0,0, 32'h0,        32'h2C, 0,1, 0,32'h0,        32'h28, 0);
        // halt arriving through the skid
        add(1,0,1,0, 32'h66666666, 32'h2C, 1,1, 1,32'h66666666, 32'h2C, 0);
        add(1,0,1,1, 32'hFC000001, 32'h30, 1,1, 1,32'h66666666, 32'h2C, 0);
        add(1,0,0,0, 32'h0,        32'h34, 0,0, 1,32'hFC000001, 32'h30, 1);
        add(1,1,0,0, 32'h0,        32'h34, 1,0, 0,32'h0,        32'h30, 0);
        // sync reset in WAIT_ID (flush also high: reset wins, pcen stays 0)
        add(1,0,1,0, 32'h77777777, 32'h34, 1,1, 1,32'h77777777, 32'h34, 0);
        add(1,0,1,1, 32'h88888888, 32'h38, 1,1, 1,32'h77777777, 32'h34, 0);
        add(0,1,1,1, 32'h99999999, 32'h3C, 0,0, 0,32'h0,        32'h0,  0);
        add(1,0,0,0, 32'h0,        32'h3C, 0,1, 0,32'h0,        32'h0,  0);

        @(posedge CLK);
        #1;
        for (int i = 0; i < tbl.size(); i++)
            step(i, tbl[i]);

        // back-to-back skid cycles with a long stall, checked against a fixed expectation
        t = '{1,0,1,0, 32'hA0000001, 32'h40, 1,1, 1,32'hA0000001, 32'h40, 0};
        step(100, t);
        t = '{1,0,1,1, 32'hA0000002, 32'h44, 1,1, 1,32'hA0000001, 32'h40, 0};
        step(101, t);
        for (int i = 0; i < 5; i++) begin
            t = '{1,0,0,1, 32'h0, 32'h48, 0,0, 1,32'hA0000001, 32'h40, 0};
            step(102 + i, t);
        end
        t = '{1,0,0,0, 32'h0, 32'h48, 0,0, 1,32'hA0000002, 32'h44, 0};
        step(107, t);
        t = '{1,0,1,1, 32'hA0000003, 32'h48, 1,1, 1,32'hA0000002, 32'h44, 0};
        step(108, t);
        t = '{1,0,0,0, 32'h0, 32'h4C, 0,0, 1,32'hA0000003, 32'h48, 0};
        step(109, t);

        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard drain: %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
